// File: rtl/led_strip_scheduler_pkg.sv
// Shared definitions for the LED-strip frame scheduler.
//   LED_BITS  : GRB bits per LED, green MSB first
//   state_t   : frame sequencer states
//   pick_game : round-robin decision between the two requesters
package led_strip_scheduler_pkg;

    localparam int LED_BITS = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SEND  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_LATCH = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Game wins when it asks alone, or when both ask and idle had the last frame.
    function automatic logic pick_game(input logic req_game, input logic req_idle,
                                       input logic last_idle);
        return req_game && (!req_idle || last_idle);
    endfunction

endpackage

// File: rtl/led_strip_scheduler_gap_timer.sv
// Loadable down-counter that times the latch (line-low) gap after a frame.
//   clk, clr : clock, asynchronous active-low reset
//   load     : reload to RESET_CYCLES-1
//   en       : count down by one (saturates at zero)
//   zero     : counter is at zero
module strip_gap_timer #(
    parameter int RESET_CYCLES = 2500
) (
    input  logic clk,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)                   cnt <= '0;
        else if (load)              cnt <= CW'(RESET_CYCLES - 1);
        else if (en && cnt != '0)   cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/led_strip_scheduler.sv
// Frame sequencer and round-robin arbiter for a shared GRB LED-strip encoder.
//   clk, clr            : clock, asynchronous active-low reset
//   req_game/req_idle   : level frame requests
//   gnt_game/gnt_idle   : grant, held for the whole frame
//   pix_game/pix_idle   : GRB value of LED pix_idx from each requester
//   pix_idx             : LED currently fetched
//   num_leds            : LEDs in the frame, sampled at frame start, clamped to MAX_LEDS
//   enc_start/enc_bit   : one-cycle start strobe and bit value to the encoder
//   enc_done            : encoder finished the current bit (only honoured in WAIT)
//   enc_latch           : encoder holds the line low for the latch gap
//   busy, frame_done    : frame in progress, end-of-frame pulse
module led_strip_scheduler
    import led_strip_scheduler_pkg::*;
#(
    parameter  int MAX_LEDS     = 8,
    parameter  int BITS_PER_LED = LED_BITS,
    parameter  int RESET_CYCLES = 2500,
    localparam int IDX_W        = (MAX_LEDS > 1) ? $clog2(MAX_LEDS) : 1,
    localparam int NUM_W        = IDX_W + 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    req_game,
    input  logic                    req_idle,
    output logic                    gnt_game,
    output logic                    gnt_idle,
    input  logic [BITS_PER_LED-1:0] pix_game,
    input  logic [BITS_PER_LED-1:0] pix_idle,
    output logic [IDX_W-1:0]        pix_idx,
    input  logic [NUM_W-1:0]        num_leds,
    output logic                    enc_start,
    output logic                    enc_bit,
    input  logic                    enc_done,
    output logic                    enc_latch,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int BC_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;

    state_t                  state_q, state_d;
    logic                    last_idle;      // idle requester owned the previous frame
    logic [NUM_W-1:0]        nleds;          // frame length, frozen at frame start
    logic [BITS_PER_LED-1:0] shreg;
    logic [BC_W-1:0]         bitcnt;
    logic [NUM_W-1:0]        nleds_in;
    logic                    req_any, win_game, last_pix;
    logic                    gap_load, gap_zero;

    assign req_any  = req_game | req_idle;
    assign win_game = pick_game(req_game, req_idle, last_idle);
    assign nleds_in = (num_leds > NUM_W'(MAX_LEDS)) ? NUM_W'(MAX_LEDS) : num_leds;
    // Only evaluated in NEXT, where nleds is known to be non-zero.
    assign last_pix = ({1'b0, pix_idx} == nleds - 1'b1);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_any) state_d = (nleds_in == '0) ? ST_LATCH : ST_LOAD;
            ST_LOAD:  state_d = ST_SEND;
            ST_SEND:  state_d = ST_WAIT;
            ST_WAIT:  if (enc_done) state_d = (bitcnt == '0) ? ST_NEXT : ST_SEND;
            ST_NEXT:  state_d = last_pix ? ST_LATCH : ST_LOAD;
            ST_LATCH: if (gap_zero) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            gnt_game  <= 1'b0;
            gnt_idle  <= 1'b0;
            last_idle <= 1'b1;
            nleds     <= '0;
            pix_idx   <= '0;
            shreg     <= '0;
            bitcnt    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (req_any) begin
                    gnt_game <= win_game;
                    gnt_idle <= !win_game;
                    nleds    <= nleds_in;
                    pix_idx  <= '0;
                end
                ST_LOAD: begin
                    shreg  <= gnt_game ? pix_game : pix_idle;
                    bitcnt <= BC_W'(BITS_PER_LED - 1);
                end
                ST_WAIT: if (enc_done && bitcnt != '0) begin
                    shreg  <= shreg << 1;
                    bitcnt <= bitcnt - 1'b1;
                end
                ST_NEXT: if (!last_pix) pix_idx <= pix_idx + 1'b1;
                ST_DONE: begin
                    gnt_game  <= 1'b0;
                    gnt_idle  <= 1'b0;
                    last_idle <= gnt_idle;
                end
                default: ;
            endcase
        end
    end

    // Reload on every entry into LATCH so the gap is exactly RESET_CYCLES long.
    assign gap_load = (state_d == ST_LATCH) && (state_q != ST_LATCH);

    strip_gap_timer #(.RESET_CYCLES(RESET_CYCLES)) u_gap (
        .clk  (clk),
        .clr  (clr),
        .load (gap_load),
        .en   (state_q == ST_LATCH),
        .zero (gap_zero)
    );

    assign busy       = (state_q != ST_IDLE);
    assign enc_start  = (state_q == ST_SEND);
    // Masked outside SEND/WAIT so the line to the encoder reads 0 between frames.
    assign enc_bit    = shreg[BITS_PER_LED-1] & ((state_q == ST_SEND) || (state_q == ST_WAIT));
    assign enc_latch  = (state_q == ST_LATCH);
    assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_led_strip_scheduler.sv
// Self-checking bench for led_strip_scheduler: encoder model, frame tables,
// corner-case sequences and randomized frames against a bit-queue reference.
module tb_led_strip_scheduler;

    localparam int MAX_LEDS     = 8;
    localparam int RESET_CYCLES = 2500;
    localparam int ENC_LAT      = 10;
    localparam int FRAME_BUDGET = 8000;

    logic        clk, clr, req_game, req_idle, gnt_game, gnt_idle;
    logic [23:0] pix_game, pix_idle;
    logic [2:0]  pix_idx;
    logic [3:0]  num_leds;
    logic        enc_start, enc_bit, enc_done, enc_latch, busy, frame_done;

    logic [23:0] game_mem [MAX_LEDS];
    logic [23:0] idle_mem [MAX_LEDS];

    assign pix_game = game_mem[pix_idx];
    assign pix_idle = idle_mem[pix_idx];

    led_strip_scheduler dut (
        .clk(clk), .clr(clr), .req_game(req_game), .req_idle(req_idle),
        .gnt_game(gnt_game), .gnt_idle(gnt_idle), .pix_game(pix_game),
        .pix_idle(pix_idle), .pix_idx(pix_idx), .num_leds(num_leds),
        .enc_start(enc_start), .enc_bit(enc_bit), .enc_done(enc_done),
        .enc_latch(enc_latch), .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec, n_err;
    int   cd, dones, latch_run, last_latch, model_last;
    logic cur_bit, spur;
    logic [1:0] done_gnt;
    logic bits_q [$];
    logic exp_q [$];
    logic [1:0] gnt_log [$];

    typedef struct {
        logic       rg;
        logic       ri;
        logic [3:0] nl;
        int         exp_starts;
        int         exp_win;     // 0 game, 1 idle
    } vec_t;
    vec_t tv [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample DUT at the falling edge, run the encoder model, drive enc_done.
    task automatic tick();
        @(negedge clk);
        if (frame_done) begin
            dones++;
            done_gnt = {gnt_idle, gnt_game};
            gnt_log.push_back(done_gnt);
        end
        if (enc_latch) latch_run++;
        else if (latch_run != 0) begin
            last_latch = latch_run;
            latch_run  = 0;
        end
        enc_done = 1'b0;
        if (cd != 0) begin
            cd--;
            if (cd == 0) begin
                enc_done = 1'b1;
                chk("enc_bit_hold", {31'd0, enc_bit}, {31'd0, cur_bit});
            end
        end
        if (enc_start) begin
            bits_q.push_back(enc_bit);
            cur_bit = enc_bit;
            cd      = ENC_LAT;
        end
        if (spur) begin
            enc_done = 1'b1;
            spur     = 1'b0;
        end
    endtask

    task automatic clear_logs();
        bits_q.delete();
        exp_q.delete();
        gnt_log.delete();
        dones      = 0;
        last_latch = 0;
        latch_run  = 0;
        done_gnt   = 2'b00;
    endtask

    task automatic add_led_bits(input logic [23:0] px);
        for (int b = 23; b >= 0; b--) exp_q.push_back(px[b]);
    endtask

    task automatic compare_bits(input string tag);
        int n;
        chk($sformatf("%s_bit_count", tag), bits_q.size(), exp_q.size());
        n = (bits_q.size() < exp_q.size()) ? bits_q.size() : exp_q.size();
        for (int k = 0; k < n; k++)
            chk($sformatf("%s_bit%0d", tag, k), {31'd0, bits_q[k]}, {31'd0, exp_q[k]});
    endtask

    function automatic int pick(input logic rg, input logic ri, input int last);
        if (rg && ri) return (last == 1) ? 0 : 1;
        return rg ? 0 : 1;
    endfunction

    task automatic wait_done(input string tag);
        for (int i = 0; i < FRAME_BUDGET && dones == 0; i++) tick();
        chk($sformatf("%s_done_seen", tag), {31'd0, dones != 0}, 1);
    endtask

    // Finish a frame already in flight and check it against the reference.
    task automatic check_frame(input logic [3:0] nl, input int win, input string tag);
        int n;
        wait_done(tag);
        repeat (3) tick();
        chk($sformatf("%s_done_count", tag), dones, 1);
        chk($sformatf("%s_idle_after", tag), {31'd0, busy}, 0);
        chk($sformatf("%s_winner", tag), {30'd0, done_gnt}, (win == 1) ? 2'b10 : 2'b01);
        chk($sformatf("%s_latch_len", tag), last_latch, RESET_CYCLES);
        n = (int'(nl) > MAX_LEDS) ? MAX_LEDS : int'(nl);
        exp_q.delete();
        for (int l = 0; l < n; l++) add_led_bits((win == 1) ? idle_mem[l] : game_mem[l]);
        compare_bits(tag);
        model_last = win;
    endtask

    task automatic run_frame(input logic rg, input logic ri, input logic [3:0] nl,
                             input int win, input string tag);
        clear_logs();
        req_game = rg;
        req_idle = ri;
        num_leds = nl;
        tick();
        req_game = 1'b0;
        req_idle = 1'b0;
        chk($sformatf("%s_busy", tag), {31'd0, busy}, 1);
        check_frame(nl, win, tag);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rg, ri;
        logic [3:0] nl;
        int         win;

        n_vec = 0; n_err = 0; cd = 0; spur = 1'b0; cur_bit = 1'b0;
        clr = 1'b0; req_game = 1'b0; req_idle = 1'b0; num_leds = 4'd0; enc_done = 1'b0;
        model_last = 1;
        clear_logs();
        game_mem[0] = 24'hA50F01; game_mem[1] = 24'h800001;
        for (int i = 2; i < MAX_LEDS; i++) game_mem[i] = 24'h111111 * 24'(i);
        for (int i = 0; i < MAX_LEDS; i++) idle_mem[i] = 24'h5A3C00 ^ 24'(i * 24'h010203);

        // reset state
        repeat (2) tick();
        chk("rst_state", {22'd0, gnt_game, gnt_idle, pix_idx, enc_start, enc_bit,
                          enc_latch, busy, frame_done}, 0);
        clr = 1'b1;
        repeat (2) tick();

        // frame table: single requesters, empty and oversize frames, ties
        tv[0] = '{1'b1, 1'b0, 4'd2,  48,  0};
        tv[1] = '{1'b0, 1'b1, 4'd0,  0,   1};
        tv[2] = '{1'b1, 1'b0, 4'd12, 192, 0};
        tv[3] = '{1'b1, 1'b1, 4'd1,  24,  1};
        tv[4] = '{1'b1, 1'b1, 4'd1,  24,  0};
        for (int i = 0; i < 5; i++) begin
            run_frame(tv[i].rg, tv[i].ri, tv[i].nl, tv[i].exp_win, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_starts", i), bits_q.size(), tv[i].exp_starts);
        end

        // request dropped and num_leds changed after the first bit starts
        clear_logs();
        game_mem[0] = 24'($urandom); game_mem[1] = 24'($urandom);
        req_game = 1'b1; num_leds = 4'd2;
        tick();
        for (int i = 0; i < 20 && bits_q.size() == 0; i++) tick();
        req_game = 1'b0; num_leds = 4'd7;
        check_frame(4'd2, 0, "drop");

        // spurious enc_done in IDLE, start latency, spurious enc_done in LATCH
        spur = 1'b1;
        tick(); tick();
        chk("spur_idle_busy", {31'd0, busy}, 0);
        chk("spur_idle_start", {31'd0, enc_start}, 0);
        clear_logs();
        game_mem[0] = 24'($urandom);
        num_leds = 4'd1; req_game = 1'b1;
        tick();
        chk("lat_cycle1", {31'd0, enc_start}, 0);
        req_game = 1'b0;
        tick();
        chk("lat_cycle2", {31'd0, enc_start}, 1);
        for (int i = 0; i < 1000 && !enc_latch; i++) tick();
        spur = 1'b1;
        check_frame(4'd1, 0, "spur");

        // reset in the middle of a bit
        clear_logs();
        game_mem[0] = 24'hA50F01; num_leds = 4'd1; req_game = 1'b1;
        tick();
        req_game = 1'b0;
        for (int i = 0; i < 20 && bits_q.size() == 0; i++) tick();
        repeat (3) tick();
        chk("pre_rst_busy", {31'd0, busy}, 1);
        chk("pre_rst_bit", {31'd0, enc_bit}, 1);
        chk("pre_rst_gnt", {31'd0, gnt_game}, 1);
        clr = 1'b0; cd = 0; enc_done = 1'b0;
        #1;
        chk("rst_async", {22'd0, gnt_game, gnt_idle, pix_idx, enc_start, enc_bit,
                          enc_latch, busy, frame_done}, 0);
        repeat (2) tick();
        clr = 1'b1; model_last = 1;
        repeat (30) tick();
        chk("rst_no_done", dones, 0);
        chk("rst_idle", {31'd0, busy}, 0);

        // both requesters held from reset: game, idle, game
        clear_logs();
        clr = 1'b0; req_game = 1'b1; req_idle = 1'b1; num_leds = 4'd1;
        repeat (2) tick();
        clr = 1'b1; model_last = 1;
        for (int i = 0; i < 12000 && gnt_log.size() < 3; i++) tick();
        req_game = 1'b0; req_idle = 1'b0;
        repeat (3) tick();
        chk("alt_frames", gnt_log.size(), 3);
        if (gnt_log.size() >= 3) begin
            chk("alt_f0", {30'd0, gnt_log[0]}, 2'b01);
            chk("alt_f1", {30'd0, gnt_log[1]}, 2'b10);
            chk("alt_f2", {30'd0, gnt_log[2]}, 2'b01);
        end
        exp_q.delete();
        add_led_bits(game_mem[0]); add_led_bits(idle_mem[0]); add_led_bits(game_mem[0]);
        compare_bits("alt");
        model_last = 0;

        // randomized frames against the reference model
        for (int f = 0; f < 6; f++) begin
            rg = 1'($urandom_range(0, 1));
            ri = rg ? 1'($urandom_range(0, 1)) : 1'b1;
            nl = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 5) == 0) nl = 4'($urandom_range(9, 15));
            for (int i = 0; i < MAX_LEDS; i++) begin
                game_mem[i] = 24'($urandom);
                idle_mem[i] = 24'($urandom);
            end
            win = pick(rg, ri, model_last);
            repeat ($urandom_range(0, 4)) tick();
            run_frame(rg, ri, nl, win, $sformatf("rnd%0d", f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
